// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU, DMA and memory-side signals around the shared 16-bit memory port.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic        dma_lock;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [15:0] dma_rdata;

  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_we, mem_re, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_we, mem_re, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// CPU/DMA arbiter for the single memory port: CPU fixed priority, a starvation counter that
// guarantees DMA progress, and bounded locked DMA bursts followed by a one-cycle CPU window.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned WAIT_W    = 4,
  parameter int unsigned BURST_W   = 3
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StDmaBurst, StCool} state_e;

  state_e               r_state;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [BURST_W-1:0]   r_beat_cnt;
  logic                 r_cpu_rvalid;
  logic                 r_dma_rvalid;

  logic                 w_cpu_gnt;
  logic                 w_dma_gnt;
  logic                 w_dma_starved;
  logic [BURST_W-1:0]   w_beat_inc;

  assign w_dma_starved = bus.dma_req && (r_wait_cnt == WAIT_W'(MAX_WAIT));
  assign w_beat_inc    = r_beat_cnt + 1'b1;

  // Grants are gated by reset so an asynchronous reset kills the access at once.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    if (!reset) begin
      case (r_state)
        StIdle: begin
          if (w_dma_starved)     w_dma_gnt = 1'b1;
          else if (bus.cpu_req)  w_cpu_gnt = 1'b1;
          else                   w_dma_gnt = bus.dma_req;
        end
        StDmaBurst: w_dma_gnt = bus.dma_req;
        StCool: begin
          w_cpu_gnt = bus.cpu_req;
          w_dma_gnt = bus.dma_req && !bus.cpu_req;
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.dma_gnt    = w_dma_gnt;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.dma_rvalid = r_dma_rvalid;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;

  assign bus.mem_addr  = w_dma_gnt ? bus.dma_addr  : bus.cpu_addr;
  assign bus.mem_wdata = w_dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.mem_we    = (w_cpu_gnt & bus.cpu_we)  | (w_dma_gnt & bus.dma_we);
  assign bus.mem_re    = (w_cpu_gnt & ~bus.cpu_we) | (w_dma_gnt & ~bus.dma_we);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_wait_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt && !bus.cpu_we;
      r_dma_rvalid <= w_dma_gnt && !bus.dma_we;

      if (!bus.dma_req || w_dma_gnt) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (w_dma_gnt && bus.dma_lock) begin
            r_state    <= StDmaBurst;
            r_beat_cnt <= BURST_W'(1);
          end
        end
        StDmaBurst: begin
          if (w_dma_gnt) r_beat_cnt <= w_beat_inc;
          // The beat granted now is the last one allowed once the count reaches MAX_BURST.
          if (!bus.dma_req || !bus.dma_lock) begin
            r_state <= StIdle;
          end else if (w_beat_inc == BURST_W'(MAX_BURST)) begin
            r_state <= StCool;
          end
        end
        StCool: begin
          r_state    <= StIdle;
          r_beat_cnt <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
